// File: rtl/keypad_scan_capture.sv
// Keypad matrix scanner. It drives one column at a time and samples the rows
// after a settle period. A single active row starts a press debounce. A press
// that stays stable long enough is reported once and recorded in a small
// newest-first history. Samples with no row or several rows are skipped.
module keypad_scan_capture #(
  parameter int unsigned ROWS            = 4,
  parameter int unsigned COLS            = 4,
  parameter int unsigned SETTLE_CYCLES   = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 20,
  parameter int unsigned DEPTH           = 2,
  localparam int unsigned KW             = $clog2(ROWS * COLS)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [ROWS-1:0]       i_row,
  input  logic                  i_clear,
  output logic [COLS-1:0]       o_col,
  output logic                  o_key_valid,
  output logic [KW-1:0]         o_key_code,
  output logic [DEPTH*KW-1:0]   o_history,
  output logic [DEPTH-1:0]      o_history_valid,
  output logic                  o_held,
  output logic [1:0]            o_state
);

  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HW = DEPTH * KW;

  typedef enum logic [1:0] {
    StScan      = 2'd0,
    StPressDb   = 2'd1,
    StHeld      = 2'd2,
    StReleaseDb = 2'd3
  } state_e;

  state_e          r_state;
  logic [CW-1:0]   r_col_idx;
  logic [SW-1:0]   r_settle;
  logic [DW-1:0]   r_db_cnt;
  logic [RW-1:0]   r_row_idx;
  logic            r_key_valid;
  logic [KW-1:0]   r_key_code;
  logic [HW-1:0]   r_history;
  logic [DEPTH-1:0] r_history_valid;

  logic            w_row_onehot;
  logic [RW-1:0]   w_row_sel;
  logic [CW-1:0]   w_col_next;
  logic            w_row_match;
  logic            w_row_bit;
  logic            w_settle_done;
  logic            w_db_done;
  logic [DW-1:0]   w_db_inc;
  logic [KW-1:0]   w_new_code;
  logic            w_accept;

  // Row decode: exactly-one-hot test and index of the active row.
  always_comb begin
    w_row_onehot = (i_row != '0) && ((i_row & (i_row - ROWS'(1))) == '0);
    w_row_sel    = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (i_row[r]) begin
        w_row_sel = RW'(r);
      end
    end
  end

  // Next-column, counter and key-code helpers shared by the FSM.
  always_comb begin
    w_col_next    = (r_col_idx == CW'(COLS - 1)) ? '0 : r_col_idx + CW'(1);
    w_row_match   = (i_row == (ROWS'(1) << r_row_idx));
    w_row_bit     = i_row[r_row_idx];
    w_settle_done = (r_settle == SW'(SETTLE_CYCLES - 1));
    w_db_done     = (r_db_cnt >= DW'(DEBOUNCE_CYCLES - 1));
    // Saturate so a long wait can never wrap back below the threshold.
    w_db_inc      = (r_db_cnt == DW'(DEBOUNCE_CYCLES)) ? r_db_cnt : r_db_cnt + DW'(1);
    w_new_code    = KW'(32'(r_row_idx) * COLS + 32'(r_col_idx));
    w_accept      = (r_state == StPressDb) && w_row_match && w_db_done;
  end

  // Scan / debounce FSM with registered key_valid and key_code.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= StScan;
      r_col_idx   <= '0;
      r_settle    <= '0;
      r_db_cnt    <= '0;
      r_row_idx   <= '0;
      r_key_valid <= 1'b0;
      r_key_code  <= '0;
    end else begin
      r_key_valid <= 1'b0;
      unique case (r_state)
        StScan: begin
          if (w_settle_done) begin
            r_settle <= '0;
            if (w_row_onehot) begin
              r_state   <= StPressDb;
              r_row_idx <= w_row_sel;
              r_db_cnt  <= '0;
            end else begin
              r_col_idx <= w_col_next;
            end
          end else begin
            r_settle <= r_settle + SW'(1);
          end
        end
        StPressDb: begin
          if (!w_row_match) begin
            r_state   <= StScan;
            r_col_idx <= w_col_next;
            r_settle  <= '0;
          end else if (w_db_done) begin
            r_state     <= StHeld;
            r_key_valid <= 1'b1;
            r_key_code  <= w_new_code;
          end else begin
            r_db_cnt <= w_db_inc;
          end
        end
        StHeld: begin
          // Only the captured row matters while the key is down.
          if (!w_row_bit) begin
            r_state  <= StReleaseDb;
            r_db_cnt <= '0;
          end
        end
        StReleaseDb: begin
          if (w_row_bit) begin
            r_state <= StHeld;
          end else if (w_db_done) begin
            r_state   <= StScan;
            r_col_idx <= w_col_next;
            r_settle  <= '0;
          end else begin
            r_db_cnt <= w_db_inc;
          end
        end
      endcase
    end
  end

  // Newest-first key history; an acceptance overrides a coincident clear.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_history       <= '0;
      r_history_valid <= '0;
    end else if (w_accept) begin
      r_history       <= (r_history << KW) | HW'(w_new_code);
      r_history_valid <= i_clear ? DEPTH'(1) : ((r_history_valid << 1) | DEPTH'(1));
    end else if (i_clear) begin
      r_history_valid <= '0;
    end
  end

  assign o_col           = COLS'(1) << r_col_idx;
  assign o_key_valid     = r_key_valid;
  assign o_key_code      = r_key_code;
  assign o_history       = r_history;
  assign o_history_valid = r_history_valid;
  assign o_held          = (r_state == StHeld) || (r_state == StReleaseDb);
  assign o_state         = r_state;

endmodule

// File: tb/tb_keypad_scan_capture.sv
// Bench for keypad_scan_capture. A simulated key matrix feeds the rows for
// whichever column the reference model expects to be driven. Every cycle is
// compared against the model. Directed sequences and a vector table pin the
// cycle-exact corner cases to hand-derived constants.
module tb_keypad_scan_capture;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int SETTLE = 4;
  localparam int DEB   = 20;
  localparam int DEPTH = 2;
  localparam int KW    = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                clr = 1'b0;
  logic [ROWS-1:0]     row = '0;
  logic [COLS-1:0]     o_col;
  logic                o_key_valid;
  logic [KW-1:0]       o_key_code;
  logic [DEPTH*KW-1:0] o_history;
  logic [DEPTH-1:0]    o_history_valid;
  logic                o_held;
  logic [1:0]          o_state;

  always #5 clk = ~clk;

  keypad_scan_capture #(
    .ROWS            (ROWS),
    .COLS            (COLS),
    .SETTLE_CYCLES   (SETTLE),
    .DEBOUNCE_CYCLES (DEB),
    .DEPTH           (DEPTH)
  ) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_row           (row),
    .i_clear         (clr),
    .o_col           (o_col),
    .o_key_valid     (o_key_valid),
    .o_key_code      (o_key_code),
    .o_history       (o_history),
    .o_history_valid (o_history_valid),
    .o_held          (o_held),
    .o_state         (o_state)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_pulse = 0;

  logic [ROWS-1:0] keys [COLS];

  // Reference model: phase numbers follow the published state encoding.
  int m_phase, m_col, m_settle, m_rowcap, m_cnt, m_code;
  bit m_kv;
  int hist[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ones(input logic [ROWS-1:0] v);
    int n = 0;
    for (int i = 0; i < ROWS; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic int low_index(input logic [ROWS-1:0] v);
    for (int i = 0; i < ROWS; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_col = 0; m_settle = 0; m_rowcap = 0; m_cnt = 0; m_code = 0; m_kv = 0;
    hist.delete();
  endtask

  task automatic model_step(input logic [ROWS-1:0] r, input bit c);
    bit accepted = 0;
    m_kv = 0;
    case (m_phase)
      0: begin
        m_settle++;
        if (m_settle >= SETTLE) begin
          m_settle = 0;
          if (ones(r) == 1) begin
            m_phase = 1; m_rowcap = low_index(r); m_cnt = 0;
          end else begin
            m_col = (m_col + 1) % COLS;
          end
        end
      end
      1: begin
        if (r != ROWS'(1 << m_rowcap)) begin
          m_phase = 0; m_col = (m_col + 1) % COLS; m_settle = 0;
        end else begin
          m_cnt++;
          if (m_cnt >= DEB) begin m_phase = 2; accepted = 1; end
        end
      end
      2: if (!r[m_rowcap]) begin m_phase = 3; m_cnt = 0; end
      default: begin
        if (r[m_rowcap]) m_phase = 2;
        else begin
          m_cnt++;
          if (m_cnt >= DEB) begin m_phase = 0; m_col = (m_col + 1) % COLS; m_settle = 0; end
        end
      end
    endcase
    if (c) hist.delete();
    if (accepted) begin
      m_code = m_rowcap * COLS + m_col;
      m_kv = 1;
      hist.push_front(m_code);
      if (hist.size() > DEPTH) void'(hist.pop_back());
    end
  endtask

  task automatic check_model();
    chk("m_state", 64'(o_state), 64'(m_phase));
    chk("m_col", 64'(o_col), 64'(1 << m_col));
    chk("m_key_valid", 64'(o_key_valid), 64'(m_kv));
    chk("m_key_code", 64'(o_key_code), 64'(m_code));
    chk("m_held", 64'(o_held), 64'(m_phase >= 2));
    chk("m_hist_valid", 64'(o_history_valid), 64'((1 << hist.size()) - 1));
    for (int k = 0; k < hist.size(); k++) chk("m_hist_slot", 64'(o_history[k*KW +: KW]), 64'(hist[k]));
  endtask

  task automatic cycle(input bit c);
    logic [ROWS-1:0] r;
    r = keys[m_col];
    row = r;
    clr = c;
    @(posedge clk);
    model_step(r, c);
    #1;
    if (o_key_valid) n_pulse++;
    check_model();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0);
  endtask

  task automatic clear_keys();
    for (int c = 0; c < COLS; c++) keys[c] = '0;
  endtask

  task automatic check_reset_values();
    chk("rst_state", 64'(o_state), 0);
    chk("rst_col", 64'(o_col), 1);
    chk("rst_key_valid", 64'(o_key_valid), 0);
    chk("rst_key_code", 64'(o_key_code), 0);
    chk("rst_history", 64'(o_history), 0);
    chk("rst_hist_valid", 64'(o_history_valid), 0);
    chk("rst_held", 64'(o_held), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0; row = '0;
    clear_keys();
    model_reset();
    @(posedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    rst = 1'b0;
    n_pulse = 0;
  endtask

  typedef struct {
    int r; int c; int r2; int hold; int rel;
    int pulses; int code; int hv; int st_hold; int st_rel;
  } vec_t;

  vec_t vecs [8];

  initial begin
    for (int c = 0; c < COLS; c++) keys[c] = '0;
    vecs[0] = '{1, 2, -1, 60, 30, 1, 6, 1, 2, 0};
    vecs[1] = '{2, 1, -1, 60, 30, 1, 9, 1, 2, 0};
    vecs[2] = '{0, 3, -1, 60, 10, 1, 3, 1, 2, 3};
    vecs[3] = '{3, 0, -1, 60, 30, 1, 12, 1, 2, 0};
    vecs[4] = '{0, 1, 2, 60, 30, 0, 0, 0, 0, 0};
    vecs[5] = '{1, 0, -1, 3, 30, 0, 0, 0, 0, 0};
    vecs[6] = '{1, 0, -1, 23, 30, 0, 0, 0, 1, 0};
    vecs[7] = '{1, 0, -1, 24, 30, 1, 4, 1, 2, 0};

    // Key 6 (row 1, col 2): sampled on edge 12, accepted on edge 32.
    do_reset();
    keys[2] = 4'b0010;
    for (int i = 1; i <= 31; i++) begin
      cycle(1'b0);
      if (i == 12) chk("press_db_entry", 64'(o_state), 1);
    end
    chk("no_early_valid", 64'(n_pulse), 0);
    cycle(1'b0);
    chk("accept_valid", 64'(o_key_valid), 1);
    chk("accept_state", 64'(o_state), 2);
    chk("accept_code", 64'(o_key_code), 6);
    chk("accept_slot0", 64'(o_history[3:0]), 6);
    chk("accept_hv", 64'(o_history_valid), 1);
    run(25);
    chk("no_auto_repeat", 64'(n_pulse), 1);

    // Short release then re-press returns to HELD without a second pulse.
    keys[2] = '0;
    run(5);
    chk("short_release_state", 64'(o_state), 3);
    keys[2] = 4'b0010;
    run(1);
    chk("repress_state", 64'(o_state), 2);
    chk("repress_no_pulse", 64'(n_pulse), 1);
    keys[2] = '0;
    run(20);
    chk("release_db_not_done", 64'(o_state), 3);
    run(1);
    chk("release_to_scan", 64'(o_state), 0);
    chk("release_col_adv", 64'(o_col), 4'b1000);

    // Second key 9 (row 2, col 1) then third key 3 (row 0, col 3).
    keys[1] = 4'b0100;
    run(32);
    chk("k9_slot0", 64'(o_history[3:0]), 9);
    chk("k9_slot1", 64'(o_history[7:4]), 6);
    chk("k9_hv", 64'(o_history_valid), 2'b11);
    keys[1] = '0;
    run(21);
    keys[3] = 4'b0001;
    run(28);
    chk("k3_code", 64'(o_key_code), 3);
    chk("k3_slot0", 64'(o_history[3:0]), 3);
    chk("k3_slot1", 64'(o_history[7:4]), 9);
    keys[3] = '0;
    run(21);

    // Clear in the same cycle as acceptance of key 6.
    keys[2] = 4'b0010;
    run(31);
    chk("pre_clear_hv", 64'(o_history_valid), 2'b11);
    cycle(1'b1);
    chk("clear_accept_kv", 64'(o_key_valid), 1);
    chk("clear_accept_hv", 64'(o_history_valid), 2'b01);
    chk("clear_accept_slot0", 64'(o_history[3:0]), 6);
    run(5);
    cycle(1'b1);
    chk("clear_in_held_hv", 64'(o_history_valid), 0);

    // Bounce on the 10th PRESS_DB clock.
    do_reset();
    keys[2] = 4'b0010;
    run(12);
    chk("bounce_entry", 64'(o_state), 1);
    run(9);
    keys[2] = '0;
    run(1);
    chk("bounce_state", 64'(o_state), 0);
    chk("bounce_col", 64'(o_col), 4'b1000);
    chk("bounce_no_pulse", 64'(n_pulse), 0);

    // Ghost: rows 0 and 2 both active in column 1.
    do_reset();
    keys[1] = 4'b0101;
    run(8);
    chk("ghost_state", 64'(o_state), 0);
    chk("ghost_col", 64'(o_col), 4'b0100);

    // Reset mid-debounce at count 15.
    do_reset();
    keys[2] = 4'b0010;
    run(27);
    chk("pre_reset_state", 64'(o_state), 1);
    rst = 1'b1;
    #1;
    chk("midreset_state", 64'(o_state), 0);
    chk("midreset_col", 64'(o_col), 4'b0001);
    chk("midreset_kv", 64'(o_key_valid), 0);
    chk("midreset_held", 64'(o_held), 0);
    model_reset();
    clear_keys();
    @(negedge clk);
    rst = 1'b0;
    run(30);
    chk("midreset_no_pulse", 64'(n_pulse), 0);

    // Table-driven directed vectors, each from reset.
    for (int v = 0; v < 8; v++) begin
      do_reset();
      keys[vecs[v].c][vecs[v].r] = 1'b1;
      if (vecs[v].r2 >= 0) keys[vecs[v].c][vecs[v].r2] = 1'b1;
      run(vecs[v].hold);
      chk($sformatf("vec%0d_state_hold", v), 64'(o_state), 64'(vecs[v].st_hold));
      clear_keys();
      run(vecs[v].rel);
      chk($sformatf("vec%0d_pulses", v), 64'(n_pulse), 64'(vecs[v].pulses));
      chk($sformatf("vec%0d_code", v), 64'(o_key_code), 64'(vecs[v].code));
      chk($sformatf("vec%0d_hv", v), 64'(o_history_valid), 64'(vecs[v].hv));
      chk($sformatf("vec%0d_state_rel", v), 64'(o_state), 64'(vecs[v].st_rel));
    end

    // Randomized key activity against the model.
    do_reset();
    for (int seg = 0; seg < 200; seg++) begin
      int kind, r, r2, c, c2, len;
      kind = $urandom_range(0, 4);
      r = $urandom_range(0, ROWS - 1);
      c = $urandom_range(0, COLS - 1);
      clear_keys();
      case (kind)
        0, 1: begin
          keys[c][r] = 1'b1;
          len = $urandom_range(0, 60);
          for (int i = 0; i < len; i++) cycle($urandom_range(0, 24) == 0);
        end
        2: begin
          r2 = (r + $urandom_range(1, ROWS - 1)) % ROWS;
          keys[c][r] = 1'b1;
          keys[c][r2] = 1'b1;
          len = $urandom_range(5, 30);
          for (int i = 0; i < len; i++) cycle($urandom_range(0, 24) == 0);
        end
        3: begin
          keys[c][r] = 1'b1;
          for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 5) == 0) keys[c][r] = ~keys[c][r];
            cycle($urandom_range(0, 24) == 0);
          end
        end
        default: begin
          keys[c][r] = 1'b1;
          for (int i = 0; i < 40; i++) cycle(1'b0);
          c2 = (c + 1) % COLS;
          keys[c2][$urandom_range(0, ROWS - 1)] = 1'b1;
          for (int i = 0; i < 20; i++) cycle($urandom_range(0, 24) == 0);
        end
      endcase
      clear_keys();
      len = $urandom_range(0, 40);
      for (int i = 0; i < len; i++) cycle($urandom_range(0, 24) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
